// File: rtl/text_pkg.sv
// Shared constants and types for the text cursor writer.
//   COLS/ROWS : character screen geometry (70x30)
//   AW        : character RAM address width
//   ASCII_*   : control codes the writer reacts to
//   state_t   : writer FSM states
//   OP_*      : cursor_step operation encodings
//   addr_of() : linear RAM address of a cell, y*COLS + x
package text_pkg;

    localparam int COLS = 70;
    localparam int ROWS = 30;
    localparam int AW   = 12;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_BS = 8'h08;
    localparam logic [7:0] ASCII_SP = 8'h20;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [1:0] OP_ADVANCE = 2'd0;
    localparam logic [1:0] OP_NEWLINE = 2'd1;
    localparam logic [1:0] OP_BACK    = 2'd2;

    function automatic logic [AW-1:0] addr_of(input logic [6:0] x, input logic [4:0] y);
        logic [AW-1:0] xx;
        logic [AW-1:0] yy;
        xx = {{(AW-7){1'b0}}, x};
        yy = {{(AW-5){1'b0}}, y};
        return yy * AW'(COLS) + xx;
    endfunction

endpackage

// File: rtl/cursor_step.sv
// Combinational next-cursor calculator.
//   x, y      : current cursor position
//   op        : OP_ADVANCE, OP_NEWLINE or OP_BACK
//   nx, ny    : resulting cursor position
//   new_row   : the step entered a new row (caller must clear it)
//   moved     : the cursor actually changed (false for backspace at the origin)
module cursor_step
    import text_pkg::*;
(
    input  logic [6:0] x,
    input  logic [4:0] y,
    input  logic [1:0] op,
    output logic [6:0] nx,
    output logic [4:0] ny,
    output logic       new_row,
    output logic       moved
);

    always_comb begin
        nx      = x;
        ny      = y;
        new_row = 1'b0;
        moved   = 1'b0;
        case (op)
            OP_ADVANCE: begin
                moved = 1'b1;
                if (x < 7'(COLS - 1)) begin
                    nx = x + 7'd1;
                end else begin
                    nx      = 7'd0;
                    new_row = 1'b1;
                end
            end
            OP_NEWLINE: begin
                moved   = 1'b1;
                nx      = 7'd0;
                new_row = 1'b1;
            end
            OP_BACK: begin
                if (x != 7'd0) begin
                    nx    = x - 7'd1;
                    moved = 1'b1;
                end else if (y != 5'd0) begin
                    nx    = 7'(COLS - 1);
                    ny    = y - 5'd1;
                    moved = 1'b1;
                end
            end
            default: ;
        endcase
        // Bottom row wraps to the top; there is no scrolling.
        if (new_row) begin
            ny = (y == 5'(ROWS - 1)) ? 5'd0 : y + 5'd1;
        end
    end

endmodule

// File: rtl/text_cursor_writer.sv
// Keyboard-to-character-RAM writer owning the text cursor.
//   clk, rst_n           : clock and asynchronous active-low reset
//   key_valid, key_ascii : key from the ASCII decoder
//   key_ready            : key accepted when key_valid & key_ready
//   wr_en/addr/data      : character RAM write port, one cell per strobe
//   cur_x, cur_y         : cursor position for caret display
// Printables are written at the cursor and advance it; enter starts a new
// row; backspace steps back and blanks the cell. Entering a row blanks all
// of its cells (CLEAR) before further keys are taken.
module text_cursor_writer
    import text_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          key_valid,
    input  logic [7:0]    key_ascii,
    output logic          key_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic [6:0]    cur_x,
    output logic [4:0]    cur_y
);

    state_t        state_q, state_d;
    logic [6:0]    cur_x_q, cur_x_d;
    logic [4:0]    cur_y_q, cur_y_d;
    logic [6:0]    clr_cnt_q, clr_cnt_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          key_ready_q, key_ready_d;

    logic [1:0]    step_op;
    logic [6:0]    step_x;
    logic [4:0]    step_y;
    logic          step_new_row;
    logic          step_moved;
    logic          printable;

    assign printable = (key_ascii >= 8'h20) && (key_ascii <= 8'h7E);

    always_comb begin
        step_op = OP_ADVANCE;
        if (key_ascii == ASCII_CR) begin
            step_op = OP_NEWLINE;
        end else if (key_ascii == ASCII_BS) begin
            step_op = OP_BACK;
        end
    end

    cursor_step u_step (
        .x       (cur_x_q),
        .y       (cur_y_q),
        .op      (step_op),
        .nx      (step_x),
        .ny      (step_y),
        .new_row (step_new_row),
        .moved   (step_moved)
    );

    always_comb begin
        logic take_step;
        take_step   = 1'b0;
        state_d     = state_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        clr_cnt_d   = clr_cnt_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        key_ready_d = key_ready_q;

        case (state_q)
            IDLE: begin
                if (key_valid && key_ready_q) begin
                    if (printable) begin
                        // Write lands on the old cell even when the step wraps the line.
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_of(cur_x_q, cur_y_q);
                        wr_data_d = key_ascii;
                        take_step = 1'b1;
                    end else if (key_ascii == ASCII_CR) begin
                        take_step = 1'b1;
                    end else if (key_ascii == ASCII_BS) begin
                        // Backspace blanks the cell it moves onto.
                        if (step_moved) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = addr_of(step_x, step_y);
                            wr_data_d = ASCII_SP;
                        end
                        take_step = 1'b1;
                    end
                    if (take_step) begin
                        cur_x_d = step_x;
                        cur_y_d = step_y;
                        if (step_new_row) begin
                            state_d     = CLEAR;
                            key_ready_d = 1'b0;
                            clr_cnt_d   = 7'd0;
                        end
                    end
                end
            end
            CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_of(clr_cnt_q, cur_y_q);
                wr_data_d = ASCII_SP;
                if (clr_cnt_q == 7'(COLS - 1)) begin
                    state_d     = IDLE;
                    key_ready_d = 1'b1;
                    clr_cnt_d   = 7'd0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 7'd1;
                end
            end
            default: begin
                state_d     = IDLE;
                key_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_x_q     <= 7'd0;
            cur_y_q     <= 5'd0;
            clr_cnt_q   <= 7'd0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 8'd0;
            key_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            clr_cnt_q   <= clr_cnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            key_ready_q <= key_ready_d;
        end
    end

    assign key_ready = key_ready_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign cur_x     = cur_x_q;
    assign cur_y     = cur_y_q;

endmodule

// File: tb/tb_text_cursor_writer.sv
module tb_text_cursor_writer;

    logic        clk;
    logic        rst_n;
    logic        key_valid;
    logic [7:0]  key_ascii;
    logic        key_ready;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [6:0]  cur_x;
    logic [4:0]  cur_y;

    int vectors;
    int miscompares;

    text_cursor_writer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_ascii (key_ascii),
        .key_ready (key_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cur_x     (cur_x),
        .cur_y     (cur_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Leaves time at 1 unit after a rising edge with the design in reset-released IDLE.
    task automatic do_reset();
        key_valid = 1'b0;
        key_ascii = 8'h00;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Presents one key for one edge; caller ensures key_ready is high.
    task automatic send_key(input logic [7:0] a);
        key_valid = 1'b1;
        key_ascii = a;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (key_ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        vectors++;
        if (key_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_idle_timeout key_ready got %0b want 1", tag, key_ready);
        end
    endtask

    task automatic test_reset();
        key_valid = 1'b0;
        key_ascii = 8'h00;
        rst_n = 1'b0;
        #23;
        vectors++;
        if ({wr_en, wr_addr, wr_data, cur_x, cur_y, key_ready} !== {1'b0, 12'd0, 8'd0, 7'd0, 5'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_state got en=%0b addr=%0d data=%h x=%0d y=%0d rdy=%0b want 0,0,00,0,0,1",
                     wr_en, wr_addr, wr_data, cur_x, cur_y, key_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_key();
        send_key(8'h41);
        vectors++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 12'd0, 8'h41}) begin
            miscompares++;
            $display("FAIL single_write got en=%0b addr=%0d data=%h want 1,0,41", wr_en, wr_addr, wr_data);
        end
        vectors++;
        if ({cur_x, cur_y, key_ready} !== {7'd1, 5'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL single_cursor got x=%0d y=%0d rdy=%0b want 1,0,1", cur_x, cur_y, key_ready);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL single_strobe_len got en=%0b want 0", wr_en);
        end
    endtask

    task automatic test_back_to_back();
        int low;
        do_reset();
        for (int k = 0; k < 70; k++) begin
            key_valid = 1'b1;
            key_ascii = 8'(8'h21 + k);
            @(posedge clk);
            #1;
            vectors++;
            if ({wr_en, wr_addr, wr_data} !== {1'b1, 12'(k), 8'(8'h21 + k)}) begin
                miscompares++;
                $display("FAIL b2b_write k=%0d got en=%0b addr=%0d data=%h want 1,%0d,%h",
                         k, wr_en, wr_addr, wr_data, k, 8'(8'h21 + k));
            end
            if (k < 69) begin
                vectors++;
                if (key_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_ready k=%0d got %0b want 1", k, key_ready);
                end
            end
        end
        key_valid = 1'b0;
        vectors++;
        if ({cur_x, cur_y} !== {7'd0, 5'd1}) begin
            miscompares++;
            $display("FAIL b2b_wrap_cursor got x=%0d y=%0d want 0,1", cur_x, cur_y);
        end
        low = (key_ready === 1'b0) ? 1 : 0;
        for (int i = 1; i <= 70; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if ({wr_en, wr_addr, wr_data} !== {1'b1, 12'(69 + i), 8'h20}) begin
                miscompares++;
                $display("FAIL b2b_clear i=%0d got en=%0b addr=%0d data=%h want 1,%0d,20",
                         i, wr_en, wr_addr, wr_data, 69 + i);
            end
            if (key_ready === 1'b0) low++;
        end
        vectors++;
        if (low !== 70) begin
            miscompares++;
            $display("FAIL b2b_ready_low_cycles got %0d want 70", low);
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({wr_en, key_ready} !== {1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL b2b_after_clear got en=%0b rdy=%0b want 0,1", wr_en, key_ready);
        end
    endtask

    task automatic test_enter_wrap();
        int bad;
        do_reset();
        for (int r = 0; r < 29; r++) begin
            send_key(8'h0D);
            wait_idle("enter_setup");
        end
        for (int c = 0; c < 5; c++) send_key(8'h61);
        vectors++;
        if ({cur_x, cur_y} !== {7'd5, 5'd29}) begin
            miscompares++;
            $display("FAIL enter_setup_pos got x=%0d y=%0d want 5,29", cur_x, cur_y);
        end
        send_key(8'h0D);
        vectors++;
        if ({wr_en, cur_x, cur_y, key_ready} !== {1'b0, 7'd0, 5'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL enter_wrap got en=%0b x=%0d y=%0d rdy=%0b want 0,0,0,0", wr_en, cur_x, cur_y, key_ready);
        end
        bad = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            #1;
            if ({wr_en, wr_addr, wr_data} !== {1'b1, 12'(i), 8'h20}) begin
                bad++;
                $display("FAIL enter_clear i=%0d got en=%0b addr=%0d data=%h want 1,%0d,20",
                         i, wr_en, wr_addr, wr_data, i);
            end
        end
        vectors++;
        if (bad != 0) miscompares++;
    endtask

    task automatic test_backspace();
        do_reset();
        for (int r = 0; r < 3; r++) begin
            send_key(8'h0D);
            wait_idle("bs_setup");
        end
        send_key(8'h08);
        vectors++;
        if ({wr_en, wr_addr, wr_data, cur_x, cur_y} !== {1'b1, 12'd209, 8'h20, 7'd69, 5'd2}) begin
            miscompares++;
            $display("FAIL bs_row_back got en=%0b addr=%0d data=%h x=%0d y=%0d want 1,209,20,69,2",
                     wr_en, wr_addr, wr_data, cur_x, cur_y);
        end
        send_key(8'h08);
        vectors++;
        if ({wr_en, wr_addr, cur_x, cur_y} !== {1'b1, 12'd208, 7'd68, 5'd2}) begin
            miscompares++;
            $display("FAIL bs_col_back got en=%0b addr=%0d x=%0d y=%0d want 1,208,68,2",
                     wr_en, wr_addr, cur_x, cur_y);
        end
        do_reset();
        send_key(8'h08);
        vectors++;
        if ({wr_en, cur_x, cur_y, key_ready} !== {1'b0, 7'd0, 5'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL bs_origin got en=%0b x=%0d y=%0d rdy=%0b want 0,0,0,1", wr_en, cur_x, cur_y, key_ready);
        end
    endtask

    task automatic test_reset_mid_clear();
        int writes;
        do_reset();
        send_key(8'h0D);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
        end
        vectors++;
        if ({wr_en, wr_addr} !== {1'b1, 12'd99}) begin
            miscompares++;
            $display("FAIL rstmid_pre got en=%0b addr=%0d want 1,99", wr_en, wr_addr);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({wr_en, cur_x, cur_y, key_ready} !== {1'b0, 7'd0, 5'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL rstmid_async got en=%0b x=%0d y=%0d rdy=%0b want 0,0,0,1", wr_en, cur_x, cur_y, key_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        writes = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (wr_en === 1'b1) writes++;
        end
        vectors++;
        if ({writes, key_ready} !== {32'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL rstmid_after got writes=%0d rdy=%0b want 0,1", writes, key_ready);
        end
    endtask

    task automatic test_other_and_hold();
        do_reset();
        send_key(8'h41);
        send_key(8'h1B);
        vectors++;
        if ({wr_en, cur_x, cur_y, key_ready} !== {1'b0, 7'd1, 5'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL other_drop got en=%0b x=%0d y=%0d rdy=%0b want 0,1,0,1", wr_en, cur_x, cur_y, key_ready);
        end
        send_key(8'h0D);
        key_valid = 1'b1;
        key_ascii = 8'h42;
        for (int i = 1; i <= 70; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if ({wr_data, cur_x, cur_y} !== {8'h20, 7'd0, 5'd1}) begin
                miscompares++;
                $display("FAIL hold_blocked i=%0d got data=%h x=%0d y=%0d want 20,0,1", i, wr_data, cur_x, cur_y);
            end
        end
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        vectors++;
        if ({wr_en, wr_addr, wr_data, cur_x, cur_y} !== {1'b1, 12'd70, 8'h42, 7'd1, 5'd1}) begin
            miscompares++;
            $display("FAIL hold_accept got en=%0b addr=%0d data=%h x=%0d y=%0d want 1,70,42,1,1",
                     wr_en, wr_addr, wr_data, cur_x, cur_y);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        key_valid   = 1'b0;
        key_ascii   = 8'h00;
        rst_n       = 1'b0;
        test_reset();
        test_single_key();
        test_back_to_back();
        test_enter_wrap();
        test_backspace();
        test_reset_mid_clear();
        test_other_and_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
